// File: rtl/time_ctrl_fsm_if.sv
// rtl/time_ctrl_fsm_if.sv - button/tick/terminal-count inputs and count-strobe outputs of the time sequencer
interface time_ctrl_fsm_if;
    // Inputs to the sequencer
    logic       Tick;
    logic       ModeBtn;
    logic       IncBtn;
    logic       TcSecU;
    logic       TcSecT;
    logic       TcMinU;
    logic       TcMinT;
    logic       AlTcMinU;
    // Outputs from the sequencer
    logic       EnSecU;
    logic       EnSecT;
    logic       EnMinU;
    logic       EnMinT;
    logic       EnHr;
    logic       AlEnMinU;
    logic       AlEnMinT;
    logic       AlEnHr;
    logic       SecClrN;
    logic [2:0] State;
    logic       Blink;

    modport master (
        output Tick, ModeBtn, IncBtn, TcSecU, TcSecT, TcMinU, TcMinT, AlTcMinU,
        input  EnSecU, EnSecT, EnMinU, EnMinT, EnHr, AlEnMinU, AlEnMinT, AlEnHr,
        input  SecClrN, State, Blink
    );

    modport slave (
        input  Tick, ModeBtn, IncBtn, TcSecU, TcSecT, TcMinU, TcMinT, AlTcMinU,
        output EnSecU, EnSecT, EnMinU, EnMinT, EnHr, AlEnMinU, AlEnMinT, AlEnHr,
        output SecClrN, State, Blink
    );
endinterface

// File: rtl/time_ctrl_fsm.sv
// rtl/time_ctrl_fsm.sv - time-of-day sequencer: run cascade, hour/minute set modes, optional alarm set modes (ALARM_SET_EN)
module time_ctrl_fsm #(
    parameter int REPEAT_TICKS = 2,
    parameter int BLINK_TICKS  = 1
) (
    input  logic          Clk,
    input  logic          Clr,
    time_ctrl_fsm_if.slave bus
);

    localparam int RW = (REPEAT_TICKS < 1) ? 1 : $clog2(REPEAT_TICKS + 1);
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    typedef enum logic [2:0] {
        S_RUN        = 3'd0,
        S_SET_HR     = 3'd1,
        S_SET_MIN    = 3'd2,
        S_SET_AL_HR  = 3'd3,
        S_SET_AL_MIN = 3'd4
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic            mode_q;
    logic            inc_q;
    logic [RW-1:0]   rpt_cnt;
    logic [BW-1:0]   blink_cnt;
    logic            blink_q;

    logic            en_sec_u_q, en_sec_t_q, en_min_u_q, en_min_t_q, en_hr_q;
    logic            al_en_min_u_q, al_en_min_t_q, al_en_hr_q;
    logic            sec_clr_n_q;

    logic            en_sec_u_d, en_sec_t_d, en_min_u_d, en_min_t_d, en_hr_d;
    logic            al_en_min_u_d, al_en_min_t_d, al_en_hr_d;
    logic            sec_clr_n_d;

    logic            mode_edge;
    logic            inc_edge;
    logic            in_set;
    logic            rpt_evt;
    logic            inc_evt;
    logic            cas_min_u;
    logic            cas_min_t;

    // History regs reset high, so a button held through reset produces no edge.
    assign mode_edge = bus.ModeBtn & ~mode_q;
    assign inc_edge  = bus.IncBtn  & ~inc_q;
    assign in_set    = (state_q != S_RUN);

    // Auto-repeat fires on every Tick once the button has been held REPEAT_TICKS Ticks.
    assign rpt_evt   = in_set & bus.IncBtn & bus.Tick & (rpt_cnt >= RW'(REPEAT_TICKS));
    assign inc_evt   = in_set & (inc_edge | rpt_evt) & ~mode_edge;

    // Carry chain of the run-mode cascade.
    assign cas_min_u = bus.TcSecU & bus.TcSecT;
    assign cas_min_t = cas_min_u & bus.TcMinU;

    // Next state and next registered strobes; a mode edge pre-empts any count.
    always_comb begin
        state_d       = state_q;
        en_sec_u_d    = 1'b0;
        en_sec_t_d    = 1'b0;
        en_min_u_d    = 1'b0;
        en_min_t_d    = 1'b0;
        en_hr_d       = 1'b0;
        al_en_min_u_d = 1'b0;
        al_en_min_t_d = 1'b0;
        al_en_hr_d    = 1'b0;
        sec_clr_n_d   = 1'b1;

        if (mode_edge) begin
            case (state_q)
                S_RUN: begin
                    state_d     = S_SET_HR;
                    sec_clr_n_d = 1'b0;
                end
                S_SET_HR:     state_d = S_SET_MIN;
`ifdef ALARM_SET_EN
                S_SET_MIN:    state_d = S_SET_AL_HR;
                S_SET_AL_HR:  state_d = S_SET_AL_MIN;
                S_SET_AL_MIN: state_d = S_RUN;
`else
                S_SET_MIN:    state_d = S_RUN;
`endif
                default:      state_d = S_RUN;
            endcase
        end else begin
            case (state_q)
                S_RUN: begin
                    if (bus.Tick) begin
                        en_sec_u_d = 1'b1;
                        en_sec_t_d = bus.TcSecU;
                        en_min_u_d = cas_min_u;
                        en_min_t_d = cas_min_t;
                        en_hr_d    = cas_min_t & bus.TcMinT;
                    end
                end
                S_SET_HR: begin
                    en_hr_d = inc_evt;
                end
                S_SET_MIN: begin
                    // Minutes wrap without carrying into hours while setting.
                    en_min_u_d = inc_evt;
                    en_min_t_d = inc_evt & bus.TcMinU;
                end
`ifdef ALARM_SET_EN
                S_SET_AL_HR: begin
                    al_en_hr_d = inc_evt;
                end
                S_SET_AL_MIN: begin
                    al_en_min_u_d = inc_evt;
                    al_en_min_t_d = inc_evt & bus.AlTcMinU;
                end
`endif
                default: begin
                end
            endcase
        end
    end

`ifndef ALARM_SET_EN
    logic unused_al_tc_min_u;
    assign unused_al_tc_min_u = bus.AlTcMinU;
`endif

    // State register, button history and registered output strobes.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_q       <= S_RUN;
            mode_q        <= 1'b1;
            inc_q         <= 1'b1;
            en_sec_u_q    <= 1'b0;
            en_sec_t_q    <= 1'b0;
            en_min_u_q    <= 1'b0;
            en_min_t_q    <= 1'b0;
            en_hr_q       <= 1'b0;
            al_en_min_u_q <= 1'b0;
            al_en_min_t_q <= 1'b0;
            al_en_hr_q    <= 1'b0;
            sec_clr_n_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            mode_q        <= bus.ModeBtn;
            inc_q         <= bus.IncBtn;
            en_sec_u_q    <= en_sec_u_d;
            en_sec_t_q    <= en_sec_t_d;
            en_min_u_q    <= en_min_u_d;
            en_min_t_q    <= en_min_t_d;
            en_hr_q       <= en_hr_d;
            al_en_min_u_q <= al_en_min_u_d;
            al_en_min_t_q <= al_en_min_t_d;
            al_en_hr_q    <= al_en_hr_d;
            sec_clr_n_q   <= sec_clr_n_d;
        end
    end

    // Hold-time counter for auto-repeat; saturates, cleared on release and in RUN.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            rpt_cnt <= '0;
        end else if (!bus.IncBtn || !in_set) begin
            rpt_cnt <= '0;
        end else if (bus.Tick && (rpt_cnt < RW'(REPEAT_TICKS))) begin
            rpt_cnt <= rpt_cnt + RW'(1);
        end
    end

    // Blink phase: toggles every BLINK_TICKS Ticks in set states, restarts low on any state change.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            blink_cnt <= '0;
            blink_q   <= 1'b0;
        end else if (state_d != state_q) begin
            blink_cnt <= '0;
            blink_q   <= 1'b0;
        end else if (in_set && bus.Tick) begin
            if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
                blink_cnt <= '0;
                blink_q   <= ~blink_q;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    assign bus.EnSecU   = en_sec_u_q;
    assign bus.EnSecT   = en_sec_t_q;
    assign bus.EnMinU   = en_min_u_q;
    assign bus.EnMinT   = en_min_t_q;
    assign bus.EnHr     = en_hr_q;
    assign bus.AlEnMinU = al_en_min_u_q;
    assign bus.AlEnMinT = al_en_min_t_q;
    assign bus.AlEnHr   = al_en_hr_q;
    assign bus.SecClrN  = sec_clr_n_q;
    assign bus.State    = state_q;
    assign bus.Blink    = blink_q;

endmodule
